// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: synchronizes row sense lines, scans columns, debounces
// press/release and queues one key code per press in a small FIFO.
module keypad_scan_ctrl #(
  parameter int unsigned ROWS         = 3,
  parameter int unsigned COLS         = 3,
  parameter int unsigned SETTLE_CYC   = 2,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned CODE_W      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              key_held
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 2);
  localparam int unsigned DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [ROWS-1:0]     sync1_q, row_s_q;
  logic [COL_W-1:0]    col_idx_q, col_idx_d;
  logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [COL_W-1:0]    cap_col_q, cap_col_d;
  logic [ROWS-1:0]     cap_rows_q, cap_rows_d;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [COLS-1:0]     col_out_q, col_out_d;
  logic                key_held_q, key_held_d;

  logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                key_valid_q, key_valid_d;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic                overflow_q, overflow_d;

  logic                push_c, pop_c, full_c, push_ok_c, drop_c;
  logic [ROW_W-1:0]    low_row_c;
  logic [CODE_W-1:0]   push_code_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Lowest set captured row wins when several rows are active.
  always_comb begin
    low_row_c = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (cap_rows_q[i]) low_row_c = ROW_W'(i);
    end
    push_code_c = CODE_W'(32'(low_row_c) * COLS + 32'(cap_col_q));
  end

  // Scan/debounce FSM; deb_cnt doubles as the release counter in HOLD.
  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    settle_cnt_d = settle_cnt_q;
    cap_col_d    = cap_col_q;
    cap_rows_d   = cap_rows_q;
    deb_cnt_d    = deb_cnt_q;
    push_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (row_s_q != '0) begin
          state_d      = SCAN;
          col_idx_d    = '0;
          settle_cnt_d = '0;
        end
      end
      SCAN: begin
        // Sample after SETTLE_CYC+2 cycles so the synchronizer sees the new column.
        if (settle_cnt_q == SET_W'(SETTLE_CYC + 1)) begin
          if (row_s_q != '0) begin
            cap_col_d  = col_idx_q;
            cap_rows_d = row_s_q;
            deb_cnt_d  = '0;
            state_d    = DEBOUNCE;
          end else if (col_idx_q == COL_W'(COLS - 1)) begin
            state_d = IDLE;
          end else begin
            col_idx_d    = col_idx_q + COL_W'(1);
            settle_cnt_d = '0;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      DEBOUNCE: begin
        if (row_s_q != cap_rows_q) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
          push_c    = 1'b1;
          deb_cnt_d = '0;
          state_d   = HOLD;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      HOLD: begin
        if (row_s_q != '0) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
          state_d = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    col_out_d  = '1;
    key_held_d = 1'b0;
    unique case (state_d)
      SCAN:          col_out_d = COLS'(1) << col_idx_d;
      DEBOUNCE:      col_out_d = COLS'(1) << cap_col_d;
      HOLD: begin
        col_out_d  = COLS'(1) << cap_col_d;
        key_held_d = 1'b1;
      end
      default:       col_out_d = '1;
    endcase
  end

  // Event FIFO; head and valid are registered from next-state values.
  always_comb begin
    pop_c     = key_valid_q && key_ready;
    full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok_c = push_c && (!full_c || pop_c);
    drop_c    = push_c && full_c && !pop_c;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_code_c;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    key_valid_d = (count_d != '0);
    key_code_d  = key_valid_d ? mem_d[rd_ptr_d] : '0;
    overflow_d  = drop_c ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync1_q      <= '0;
      row_s_q      <= '0;
      col_idx_q    <= '0;
      settle_cnt_q <= '0;
      cap_col_q    <= '0;
      cap_rows_q   <= '0;
      deb_cnt_q    <= '0;
      col_out_q    <= '1;
      key_held_q   <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= row_in;
      row_s_q      <= sync1_q;
      col_idx_q    <= col_idx_d;
      settle_cnt_q <= settle_cnt_d;
      cap_col_q    <= cap_col_d;
      cap_rows_q   <= cap_rows_d;
      deb_cnt_q    <= deb_cnt_d;
      col_out_q    <= col_out_d;
      key_held_q   <= key_held_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      overflow_q   <= overflow_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_held  = key_held_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a 3x3 switch-matrix model.
module tb_keypad_scan_ctrl;

  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 3;
  localparam int unsigned NKEY = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_ready;
  logic            overflow;
  logic            clr_ovf;
  logic            key_held;

  logic [NKEY-1:0] keys;
  logic            glitch_en;
  logic [ROWS-1:0] glitch_rows;
  logic [ROWS-1:0] pad_rows;

  int n_vec = 0;
  int n_err = 0;

  keypad_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key connects its driven column to its row.
  always_comb begin
    pad_rows = '0;
    for (int k = 0; k < int'(NKEY); k++) begin
      if (keys[k] && col_out[k % int'(COLS)]) pad_rows[k / int'(COLS)] = 1'b1;
    end
  end
  assign row_in = glitch_en ? glitch_rows : pad_rows;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_held(input string tag);
    int n = 0;
    while (!key_held && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(key_held), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((key_held || col_out != 3'b111) && n < 200) begin
      tick();
      n++;
    end
    check(tag, {28'd0, key_held, col_out}, 32'h7);
  endtask

  task automatic press_release(input int code, input string tag);
    keys       = '0;
    keys[code] = 1'b1;
    wait_held({tag, "_held"});
    keys = '0;
    wait_idle({tag, "_idle"});
    repeat (3) tick();
  endtask

  initial begin
    int n;
    logic saw;
    logic [3:0] exp3 [4];
    logic [3:0] exp5 [4];
    exp3 = '{4'd0, 4'd4, 4'd8, 4'd3};
    exp5 = '{4'd2, 4'd4, 4'd5, 4'd6};

    keys        = '0;
    glitch_en   = 1'b0;
    glitch_rows = '0;
    key_ready   = 1'b0;
    clr_ovf     = 1'b0;
    rst_n       = 1'b0;
    #12;
    check("rst_col_out", 32'(col_out), 32'h7);
    check("rst_valid",   32'(key_valid), 32'd0);
    check("rst_code",    32'(key_code), 32'd0);
    check("rst_ovf",     32'(overflow), 32'd0);
    check("rst_held",    32'(key_held), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Key 5 held: one event, stable head, release timing.
    keys[5] = 1'b1;
    n = 0;
    while (!key_valid && n < 100) begin
      tick();
      n++;
    end
    check("k5_valid", 32'(key_valid), 32'd1);
    check("k5_code",  32'(key_code), 32'd5);
    check("k5_held",  32'(key_held), 32'd1);
    check("k5_col",   32'(col_out), 32'h4);
    repeat (20) tick();
    check("k5_valid_wait", 32'(key_valid), 32'd1);
    check("k5_code_wait",  32'(key_code), 32'd5);
    keys = '0;
    n = 0;
    while (key_held && n < 50) begin
      tick();
      n++;
    end
    check("k5_release_lat", 32'(n), 32'd6);
    check("k5_col_idle", 32'(col_out), 32'h7);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("k5_single_event", 32'(key_valid), 32'd0);

    // Short glitch on row 0 must not produce an event.
    glitch_rows = 3'b001;
    glitch_en   = 1'b1;
    repeat (3) tick();
    glitch_en = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      tick();
      if (key_valid) saw = 1'b1;
    end
    check("glitch_no_event", 32'(saw), 32'd0);
    check("glitch_idle", {28'd0, key_held, col_out}, 32'h7);

    // Five presses into a four-deep queue with no consumer.
    press_release(0, "ov_k0");
    press_release(4, "ov_k4");
    press_release(8, "ov_k8");
    press_release(3, "ov_k3");
    check("ov_full_valid", 32'(key_valid), 32'd1);
    check("ov_full_head",  32'(key_code), 32'd0);
    check("ov_not_yet",    32'(overflow), 32'd0);
    press_release(1, "ov_k1");
    check("ov_set",        32'(overflow), 32'd1);
    check("ov_head_kept",  32'(key_code), 32'd0);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ov_pop_valid", 32'(key_valid), 32'd1);
      check("ov_pop_code",  32'(key_code), 32'(exp3[i]));
      tick();
    end
    key_ready = 1'b0;
    check("ov_drained",  32'(key_valid), 32'd0);
    check("ov_sticky",   32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ov_cleared",  32'(overflow), 32'd0);

    // Refill, then a drop on the same cycle as clr_ovf keeps overflow set.
    press_release(1, "fill_k1");
    press_release(2, "fill_k2");
    press_release(4, "fill_k4");
    press_release(5, "fill_k5");
    check("fill_head", 32'(key_code), 32'd1);
    clr_ovf = 1'b1;
    keys[0] = 1'b1;
    repeat (10) tick();
    check("clr_pre_push_held", 32'(key_held), 32'd0);
    check("clr_pre_push_ovf",  32'(overflow), 32'd0);
    tick();
    check("clr_push_held",     32'(key_held), 32'd1);
    check("clr_drop_wins",     32'(overflow), 32'd1);
    clr_ovf = 1'b0;
    keys = '0;
    wait_idle("clr_idle");
    check("clr_head_kept", 32'(key_code), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_cleared", 32'(overflow), 32'd0);

    // Push of key 6 coincides with a pop on the full queue.
    keys[6] = 1'b1;
    repeat (10) tick();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("co_pushed",  32'(key_held), 32'd1);
    check("co_no_ovf",  32'(overflow), 32'd0);
    check("co_head",    32'(key_code), 32'd2);
    keys = '0;
    wait_idle("co_idle");
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("co_pop_valid", 32'(key_valid), 32'd1);
      check("co_pop_code",  32'(key_code), 32'(exp5[i]));
      tick();
    end
    key_ready = 1'b0;
    check("co_drained", 32'(key_valid), 32'd0);
    check("co_ovf_end", 32'(overflow), 32'd0);

    // Keys 3 and 6 together resolve to the lower row; also checks latency.
    keys[3] = 1'b1;
    keys[6] = 1'b1;
    n = 0;
    while (!key_valid && n < 100) begin
      tick();
      n++;
    end
    check("multi_latency", 32'(n), 32'd11);
    check("multi_code",    32'(key_code), 32'd3);
    keys = '0;
    wait_idle("multi_idle");
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("multi_single", 32'(key_valid), 32'd0);

    // Reset during debounce discards the press.
    keys[0] = 1'b1;
    repeat (8) tick();
    check("rd_in_debounce", 32'(col_out), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rd_col_async",   32'(col_out), 32'h7);
    check("rd_held_async",  32'(key_held), 32'd0);
    check("rd_valid_async", 32'(key_valid), 32'd0);
    tick();
    keys = '0;
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      tick();
      if (key_valid) saw = 1'b1;
    end
    check("rd_no_event", 32'(saw), 32'd0);
    press_release(7, "rd_k7");
    check("rd_k7_valid", 32'(key_valid), 32'd1);
    check("rd_k7_code",  32'(key_code), 32'd7);
    check("rd_k7_ovf",   32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
